// File: rtl/sprite_anim_engine.sv
// Player-sprite animation state plus a 2-stage sprite pixel pipeline (address, then keyed RGB).
// Optional macro SPRITE_FLIP_EN: direction 3 mirrors the direction-1 frames instead of owning a ROM region.
module sprite_anim_engine #(
  parameter int          SPR_W           = 17,
  parameter int          SPR_H           = 24,
  parameter int          POS_X           = 292,
  parameter int          POS_Y           = 350,
  parameter int          DIRS            = 4,
  parameter int          FRAMES          = 4,
  parameter int          TICKS_PER_FRAME = 8,
  parameter logic [23:0] KEY_COLOR       = 24'hFF00FF,
  parameter int          ADDR_W          = 16,
  localparam int         DIR_W           = (DIRS > 1) ? $clog2(DIRS) : 1,
  localparam int         FRM_W           = (FRAMES > 1) ? $clog2(FRAMES) : 1
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Frame_Tick,
  input  logic              Moving,
  input  logic [DIR_W-1:0]  Direction,
  input  logic [9:0]        DrawX,
  input  logic [9:0]        DrawY,
  output logic [ADDR_W-1:0] Rom_Addr,
  input  logic [23:0]       Rom_Data,
  output logic [7:0]        Red,
  output logic [7:0]        Green,
  output logic [7:0]        Blue,
  output logic [DIR_W-1:0]  Anim_Dir,
  output logic [FRM_W-1:0]  Anim_Frame
);

  localparam int CNT_W = (TICKS_PER_FRAME > 1) ? $clog2(TICKS_PER_FRAME) : 1;

  logic [CNT_W-1:0]  tick_cnt;
  logic              hit, hit1;
  logic [31:0]       x_ext, y_ext;
  logic [ADDR_W-1:0] row, col, col_eff, dir_eff, addr_next;

  // Animation state: only a Frame_Tick cycle may change it, so a whole video frame sees one sprite frame.
  always_ff @(posedge Clk) begin
    // NOTE: reset is synchronous and active-high here; it sits first so it beats a coincident Frame_Tick.
    if (Reset) begin
      Anim_Dir   <= '0;
      Anim_Frame <= '0;
      tick_cnt   <= '0;
    end else if (Frame_Tick) begin
      if (32'(Direction) >= 32'(DIRS)) begin
        // Illegal direction code: hold everything.
      end else if (!Moving) begin
        Anim_Frame <= '0;
        tick_cnt   <= '0;
      end else if (Direction != Anim_Dir) begin
        Anim_Dir   <= Direction;
        Anim_Frame <= '0;
        tick_cnt   <= '0;
      end else if (tick_cnt == CNT_W'(TICKS_PER_FRAME - 1)) begin
        tick_cnt   <= '0;
        Anim_Frame <= (Anim_Frame == FRM_W'(FRAMES - 1)) ? '0 : Anim_Frame + 1'b1;
      end else begin
        tick_cnt <= tick_cnt + 1'b1;
      end
    end
  end

  // Stage 0: box hit test and sprite-local coordinates, all unsigned.
  assign x_ext = {22'd0, DrawX};
  assign y_ext = {22'd0, DrawY};
  assign hit   = (x_ext >= 32'(POS_X)) && (x_ext <= 32'(POS_X + SPR_W - 1)) &&
                 (y_ext >= 32'(POS_Y)) && (y_ext <= 32'(POS_Y + SPR_H - 1));
  assign row   = ADDR_W'(y_ext - 32'(POS_Y));
  assign col   = ADDR_W'(x_ext - 32'(POS_X));

`ifdef SPRITE_FLIP_EN
  // Left reuses the right-facing frames, read mirrored column-wise.
  assign dir_eff = (Anim_Dir == DIR_W'(3)) ? ADDR_W'(1) : ADDR_W'(Anim_Dir);
  assign col_eff = (Anim_Dir == DIR_W'(3)) ? ADDR_W'(SPR_W - 1) - col : col;
`else
  assign dir_eff = ADDR_W'(Anim_Dir);
  assign col_eff = col;
`endif

  assign addr_next = (((dir_eff * ADDR_W'(FRAMES)) + ADDR_W'(Anim_Frame)) * ADDR_W'(SPR_H) + row)
                     * ADDR_W'(SPR_W) + col_eff;

  // Stages 1 and 2: ROM address, then keyed colour once the ROM word returns.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      Rom_Addr <= '0;
      hit1     <= 1'b0;
      Red      <= '0;
      Green    <= '0;
      Blue     <= '0;
    end else begin
      // NOTE: non-blocking assignments let hit1 be read here as last cycle's value, forming the pipeline.
      Rom_Addr <= hit ? addr_next : '0;
      hit1     <= hit;
      if (hit1 && (Rom_Data != KEY_COLOR)) begin
        {Red, Green, Blue} <= Rom_Data;
      end else begin
        {Red, Green, Blue} <= 24'd0;
      end
    end
  end

endmodule

// File: tb/tb_sprite_anim_engine.sv
// Scoreboard bench for sprite_anim_engine: stimulus queues hand-computed expectations with a due cycle,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_sprite_anim_engine;

  logic        Clk = 1'b0;
  logic        Reset, Frame_Tick, Moving;
  logic [1:0]  Direction;
  logic [9:0]  DrawX, DrawY;
  logic [15:0] Rom_Addr;
  logic [23:0] Rom_Data;
  logic [7:0]  Red, Green, Blue;
  logic [1:0]  Anim_Dir, Anim_Frame;

  sprite_anim_engine dut (
    .Clk(Clk), .Reset(Reset), .Frame_Tick(Frame_Tick), .Moving(Moving), .Direction(Direction),
    .DrawX(DrawX), .DrawY(DrawY), .Rom_Addr(Rom_Addr), .Rom_Data(Rom_Data),
    .Red(Red), .Green(Green), .Blue(Blue), .Anim_Dir(Anim_Dir), .Anim_Frame(Anim_Frame)
  );

  always #5 Clk = ~Clk;

  typedef enum int {SIG_DIR, SIG_FRAME, SIG_ADDR, SIG_RGB} sig_e;
  typedef struct {
    int          due;
    sig_e        sig;
    logic [31:0] val;
    string       name;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  always @(posedge Clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic logic [31:0] actual(input sig_e s);
    case (s)
      SIG_DIR:   return {30'd0, Anim_Dir};
      SIG_FRAME: return {30'd0, Anim_Frame};
      SIG_ADDR:  return {16'd0, Rom_Addr};
      default:   return {8'd0, Red, Green, Blue};
    endcase
  endfunction

  // Monitor: compares every expectation that has come due by this negedge.
  always @(negedge Clk) begin
    while (sb.size() > 0 && sb[0].due <= cyc) begin
      exp_t e;
      e = sb.pop_front();
      check(e.name, actual(e.sig), e.val);
    end
  end

  task automatic expect_at(input int lat, input sig_e s, input logic [31:0] v, input string name);
    exp_t e;
    e.due = cyc + lat; e.sig = s; e.val = v; e.name = name;
    sb.push_back(e);
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  // One Frame_Tick pulse followed by an idle cycle; optionally checks the resulting state.
  task automatic tick(input logic mv, input logic [1:0] d, input bit chk,
                      input logic [1:0] exp_dir, input logic [1:0] exp_frame, input string name);
    Frame_Tick = 1'b1; Moving = mv; Direction = d;
    if (chk) begin
      expect_at(1, SIG_DIR, {30'd0, exp_dir}, {name, "_dir"});
      expect_at(1, SIG_FRAME, {30'd0, exp_frame}, {name, "_frame"});
    end
    step();
    Frame_Tick = 1'b0;
    step();
  endtask

  task automatic ticks(input int n, input logic [1:0] d);
    for (int i = 0; i < n; i++) tick(1'b1, d, 1'b0, 2'd0, 2'd0, "");
  endtask

  // Present a pixel, return the ROM word one cycle later, and expect address and colour.
  task automatic pixel(input int x, input int y, input logic [15:0] exp_addr,
                       input logic [23:0] rom, input logic [23:0] exp_rgb, input string name);
    DrawX = 10'(x); DrawY = 10'(y);
    expect_at(1, SIG_ADDR, {16'd0, exp_addr}, {name, "_addr"});
    expect_at(2, SIG_RGB, {8'd0, exp_rgb}, {name, "_rgb"});
    step();
    Rom_Data = rom;
    step();
  endtask

  initial begin
    Reset = 1'b1; Frame_Tick = 1'b0; Moving = 1'b0; Direction = 2'd0;
    DrawX = 10'd0; DrawY = 10'd0; Rom_Data = 24'd0;
    step(); step();
    expect_at(0, SIG_DIR, 32'd0, "reset_dir");
    expect_at(0, SIG_FRAME, 32'd0, "reset_frame");
    expect_at(0, SIG_ADDR, 32'd0, "reset_addr");
    expect_at(0, SIG_RGB, 32'd0, "reset_rgb");
    step();
    Reset = 1'b0;
    step();

    // Walk up: frame advances on every 8th tick and wraps after 32.
    ticks(6, 2'd0);
    tick(1'b1, 2'd0, 1'b1, 2'd0, 2'd0, "tick7");
    tick(1'b1, 2'd0, 1'b1, 2'd0, 2'd1, "tick8");
    ticks(7, 2'd0);
    tick(1'b1, 2'd0, 1'b1, 2'd0, 2'd2, "tick16");
    ticks(7, 2'd0);
    tick(1'b1, 2'd0, 1'b1, 2'd0, 2'd3, "tick24");
    ticks(7, 2'd0);
    tick(1'b1, 2'd0, 1'b1, 2'd0, 2'd0, "tick32");

    // Reach frame 2 mid-count, then turn right: frame and counter clear.
    ticks(16, 2'd0);
    ticks(3, 2'd0);
    tick(1'b1, 2'd1, 1'b1, 2'd1, 2'd0, "turn_right");
    ticks(6, 2'd1);
    tick(1'b1, 2'd1, 1'b1, 2'd1, 2'd0, "cnt_clr7");
    tick(1'b1, 2'd1, 1'b1, 2'd1, 2'd1, "cnt_clr8");

    // Frame 3, then stop: frame returns to 0, direction held.
    ticks(16, 2'd1);
    tick(1'b1, 2'd1, 1'b1, 2'd1, 2'd3, "frame3");
    tick(1'b0, 2'd2, 1'b1, 2'd1, 2'd0, "stop");
    Moving = 1'b1; Direction = 2'd2; step();
    Moving = 1'b0; Direction = 2'd3; step();
    Moving = 1'b1; Direction = 2'd0; step();
    expect_at(0, SIG_DIR, 32'd1, "no_tick_dir");
    expect_at(0, SIG_FRAME, 32'd0, "no_tick_frame");
    step();

    // Down, frame 1: address generation, keying and box edges.
    tick(1'b1, 2'd2, 1'b1, 2'd2, 2'd0, "turn_down");
    ticks(7, 2'd2);
    tick(1'b1, 2'd2, 1'b1, 2'd2, 2'd1, "down_f1");
    pixel(292, 350, 16'd3672, 24'h123456, 24'h123456, "px_topleft");
    pixel(308, 373, 16'd4079, 24'hFF00FF, 24'h000000, "px_botright_key");
    pixel(300, 360, 16'd3850, 24'hABCDEF, 24'hABCDEF, "px_mid");
    pixel(309, 373, 16'd0, 24'h123456, 24'h000000, "px_right_out");
    pixel(291, 350, 16'd0, 24'h123456, 24'h000000, "px_left_out");
    pixel(292, 374, 16'd0, 24'h123456, 24'h000000, "px_below_out");

    // Left, frame 0: own region, or mirrored right frames when flipping is built in.
    tick(1'b1, 2'd3, 1'b1, 2'd3, 2'd0, "turn_left");
`ifdef SPRITE_FLIP_EN
    pixel(292, 350, 16'd1648, 24'h123456, 24'h123456, "px_left_dir");
`else
    pixel(292, 350, 16'd4896, 24'h123456, 24'h123456, "px_left_dir");
`endif

    // Reset coincident with a tick wins; DrawX/DrawY stay inside the box.
    Reset = 1'b1; Frame_Tick = 1'b1; Moving = 1'b1; Direction = 2'd1;
    expect_at(1, SIG_DIR, 32'd0, "rst_tick_dir");
    expect_at(1, SIG_FRAME, 32'd0, "rst_tick_frame");
    expect_at(1, SIG_ADDR, 32'd0, "rst_tick_addr");
    expect_at(1, SIG_RGB, 32'd0, "rst_tick_rgb");
    step();
    Reset = 1'b0; Frame_Tick = 1'b0;
    step();

    for (int i = 0; i < 20 && sb.size() > 0; i++) step();
    if (sb.size() > 0) begin
      $display("FAIL scoreboard_drain: %0d expectations left, 0 required", sb.size());
      errors += sb.size();
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
